// File: rtl/data_memory_sized.sv
// data_memory_sized
// MEM-stage data memory for the pipelined MIPS CPU. Byte/half/word accesses,
// little-endian byte lanes, sign/zero extension on loads, misalignment
// detection and an optional post-reset zero-fill of the whole array.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   MemRead     load request this cycle
//   MemWrite    store request this cycle
//   MemSize     00 byte, 01 half, 10 word, 11 reserved (treated as word)
//   MemSigned   1 = sign-extend sub-word loads, 0 = zero-extend
//   address     byte address (upper bits beyond the array wrap)
//   write_data  store data, right-aligned
//   read_data   registered load result, one-cycle latency, write-first
//   misaligned  registered flag for a rejected access
//   busy        high while the clear sequence runs; accesses are ignored
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | zero-filling word[clr_cnt] each clock, accesses ignored
// ST_READY | normal operation until the next reset
module data_memory_sized #(
    parameter int RAM_SIZE       = 512,
    parameter int RAM_SIZE_BIT   = 9,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        misaligned,
    output logic        busy
);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
    localparam logic [RAM_SIZE_BIT-1:0] CLR_LAST = RAM_SIZE_BIT'(RAM_SIZE - 1);

    state_t                  state, state_nxt;
    logic [RAM_SIZE_BIT-1:0] clr_cnt;
    logic                    clr_we;
    logic                    acc_en;

    logic [31:0]             mem [RAM_SIZE];

    logic [RAM_SIZE_BIT-1:0] idx;
    logic [1:0]              lane;
    logic                    sz_byte, sz_half;
    logic                    aligned;
    logic [3:0]              be;
    logic [31:0]             wdata_rep;
    logic [31:0]             cur_word;
    logic [31:0]             merged;
    logic [31:0]             shifted;
    logic [31:0]             ext;
    logic                    wr_ok, rd_ok, bad;

    // Address bits above the array are deliberately ignored (wrap-around).
    logic unused_addr;
    assign unused_addr = ^address[31:RAM_SIZE_BIT+2];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RST_STATE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_CLEAR && clr_cnt == CLR_LAST)
            state_nxt = ST_READY;
    end

    always_comb begin
        busy   = (state == ST_CLEAR);
        clr_we = (state == ST_CLEAR);
        acc_en = (state == ST_READY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      clr_cnt <= '0;
        else if (clr_we) clr_cnt <= clr_cnt + RAM_SIZE_BIT'(1);
    end

    // ---------------- access decode ----------------
    always_comb begin
        idx     = address[RAM_SIZE_BIT+1:2];
        lane    = address[1:0];
        sz_byte = (MemSize == 2'b00);
        sz_half = (MemSize == 2'b01);
        aligned = sz_byte | (sz_half & ~lane[0]) | (~sz_byte & ~sz_half & (lane == 2'b00));

        if (sz_byte) begin
            be        = 4'b0001 << lane;
            wdata_rep = {4{write_data[7:0]}};
        end else if (sz_half) begin
            be        = 4'b0011 << lane;
            wdata_rep = {2{write_data[15:0]}};
        end else begin
            be        = 4'b1111;
            wdata_rep = write_data;
        end

        wr_ok = acc_en & MemWrite & aligned;
        rd_ok = acc_en & MemRead & aligned;
        bad   = acc_en & (MemRead | MemWrite) & ~aligned;

        // Merged word is what the array holds after this edge; loads read it
        // so a same-cycle store is visible (write-first).
        cur_word = mem[idx];
        merged   = cur_word;
        if (wr_ok) begin
            for (int k = 0; k < 4; k++)
                if (be[k]) merged[8*k +: 8] = wdata_rep[8*k +: 8];
        end

        shifted = merged >> {lane, 3'b000};
        if (sz_byte)
            ext = {{24{MemSigned & shifted[7]}}, shifted[7:0]};
        else if (sz_half)
            ext = {{16{MemSigned & shifted[15]}}, shifted[15:0]};
        else
            ext = merged;
    end

    // Array has no reset; the clear sequencer provides defined contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (clr_we)     mem[clr_cnt] <= '0;
            else if (wr_ok) mem[idx]     <= merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data  <= '0;
            misaligned <= 1'b0;
        end else begin
            read_data  <= rd_ok ? ext : '0;
            misaligned <= bad;
        end
    end

endmodule
